// File: rtl/light_sequencer.sv
// light_sequencer: run controller for the RGB colour-cycling light.
// Produces the divided step pulse, drives the light's start/stop inputs,
// arbitrates start/stop requests from two sources round-robin, and counts
// completed colour cycles with an optional auto-stop after a burst.
module light_sequencer #(
    parameter int DIV_WIDTH   = 24,
    parameter int CNT_WIDTH   = 8,
    parameter int NUM_COLOURS = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req_start,
    input  logic [1:0]           req_stop,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic [CNT_WIDTH-1:0] burst_len,
    output logic                 step,
    output logic                 start,
    output logic                 stop,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic                 done
);

    localparam int PH_WIDTH = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;
    localparam logic [PH_WIDTH-1:0] PH_LAST = PH_WIDTH'(NUM_COLOURS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] div_max_q, div_max_d;   // latched divider terminal count (D-1)
    logic [CNT_WIDTH-1:0] burst_q, burst_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [PH_WIDTH-1:0]  phase_q, phase_d;
    logic                 rr_q, rr_d;             // last granted source
    logic                 step_q, step_d;
    logic                 start_q, start_d;
    logic                 stop_q, stop_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           grant_q, grant_d;

    logic [1:0]           eligible;
    logic [1:0]           gnt;
    logic                 tick;
    logic                 start_gnt;
    logic                 stop_gnt;
    logic                 phase_wrap;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // A request only counts when it means something in the current state
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign eligible[gi] = ((state_q == IDLE) && req_start[gi]) ||
                                  (((state_q == ARM) || (state_q == RUN)) && req_stop[gi]);
        end
    endgenerate

    assign tick       = (state_q != IDLE) && (div_cnt_q == div_max_q);
    assign start_gnt  = (|gnt) && (state_q == IDLE);
    assign stop_gnt   = (|gnt) && ((state_q == ARM) || (state_q == RUN));
    assign phase_wrap = (phase_q == PH_LAST);
    assign cnt_inc    = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_WIDTH'(1);

    // Round-robin arbiter: on contention the source after the last winner wins
    always_comb begin
        gnt  = 2'b00;
        rr_d = rr_q;
        case (eligible)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[1]) begin
            rr_d = 1'b1;
        end else if (gnt[0]) begin
            rr_d = 1'b0;
        end
    end

    // Next-state logic for the FSM, divider, phase/cycle counters and outputs
    always_comb begin
        state_d     = state_q;
        div_max_d   = div_max_q;
        burst_d     = burst_q;
        phase_d     = phase_q;
        cycle_cnt_d = cycle_cnt_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
        step_d      = tick;
        grant_d     = gnt;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                if (start_gnt) begin
                    state_d     = ARM;
                    div_max_d   = (div_val == '0) ? '0 : div_val - DIV_WIDTH'(1);
                    burst_d     = burst_len;
                    cycle_cnt_d = '0;
                    phase_d     = '0;
                end
            end
            ARM: begin
                if (stop_gnt) begin
                    state_d = DRAIN;
                end else if (tick) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    phase_d = phase_wrap ? '0 : phase_q + PH_WIDTH'(1);
                    if (phase_wrap) begin
                        cycle_cnt_d = cnt_inc;
                    end
                end
                // stop grant and burst completion collapse into one DRAIN entry
                if (stop_gnt ||
                    (tick && phase_wrap && (burst_q != '0) && (cnt_inc == burst_q))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d = (state_d == ARM);
        stop_d  = (state_d == IDLE) || (state_d == DRAIN);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any run without a done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            div_max_q   <= '0;
            burst_q     <= '0;
            cycle_cnt_q <= '0;
            phase_q     <= '0;
            rr_q        <= 1'b0;
            step_q      <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_max_q   <= div_max_d;
            burst_q     <= burst_d;
            cycle_cnt_q <= cycle_cnt_d;
            phase_q     <= phase_d;
            rr_q        <= rr_d;
            step_q      <= step_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            grant_q     <= grant_d;
        end
    end

    assign step      = step_q;
    assign start     = start_q;
    assign stop      = stop_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign cycle_cnt = cycle_cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: directed table-driven bench for light_sequencer plus
// hand-written multi-cycle sequences for bursts, saturation, arbitration
// fairness, stop during ARM and asynchronous reset.
module tb_light_sequencer;

    localparam int DW = 24;
    localparam int CW = 8;
    localparam int NV = 22;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    req_start = 2'b00;
    logic [1:0]    req_stop  = 2'b00;
    logic [DW-1:0] div_val   = '0;
    logic [CW-1:0] burst_len = '0;
    logic          step, start, stop, busy, done;
    logic [1:0]    grant;
    logic [CW-1:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    rs;
        logic [1:0]    rp;
        logic [DW-1:0] dv;
        logic [CW-1:0] bl;
        logic [14:0]   exp;   // {step,start,stop,grant,busy,cycle_cnt,done}
    } vec_t;

    vec_t vecs [NV];

    always #5 clock = ~clock;

    light_sequencer #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .NUM_COLOURS(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_start (req_start),
        .req_stop  (req_stop),
        .div_val   (div_val),
        .burst_len (burst_len),
        .step      (step),
        .start     (start),
        .stop      (stop),
        .grant     (grant),
        .busy      (busy),
        .cycle_cnt (cycle_cnt),
        .done      (done)
    );

    function automatic logic [14:0] ev(input int s, input int st, input int sp, input int g,
                                       input int b, input int c, input int d);
        return {s[0], st[0], sp[0], g[1:0], b[0], c[7:0], d[0]};
    endfunction

    function automatic logic [14:0] outs();
        return {step, start, stop, grant, busy, cycle_cnt, done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            cyc();
            if (done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_step(input string name, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            cyc();
            if (step) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // Guard against a hung run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int  nsteps;
        int  last;
        bit  seen_done;

        // rows: req_start, req_stop, div_val, burst_len, expected outputs after the edge
        vecs[0]  = '{2'b00, 2'b11, 24'd1, 8'd0, ev(0,0,1,0,0,0,0)};  // stop in IDLE ignored
        vecs[1]  = '{2'b11, 2'b11, 24'd1, 8'd0, ev(0,1,0,2,1,0,0)};  // start contest, ptr 0 -> src1
        vecs[2]  = '{2'b11, 2'b00, 24'd1, 8'd0, ev(1,0,0,0,1,0,0)};  // ARM -> RUN, start held ignored
        vecs[3]  = '{2'b11, 2'b00, 24'd1, 8'd0, ev(1,0,0,0,1,0,0)};
        vecs[4]  = '{2'b11, 2'b01, 24'd1, 8'd0, ev(1,0,1,1,1,0,0)};  // stop src0 -> DRAIN
        vecs[5]  = '{2'b00, 2'b00, 24'd1, 8'd0, ev(1,0,1,0,0,0,1)};  // back to IDLE, done
        vecs[6]  = '{2'b11, 2'b11, 24'd0, 8'd1, ev(0,1,0,2,1,0,0)};  // ptr 0 -> src1, div 0
        vecs[7]  = '{2'b00, 2'b11, 24'd1, 8'd0, ev(1,0,1,1,1,0,0)};  // stop in ARM, ptr 1 -> src0
        vecs[8]  = '{2'b00, 2'b00, 24'd1, 8'd0, ev(1,0,1,0,0,0,1)};
        vecs[9]  = '{2'b01, 2'b00, 24'd1, 8'd1, ev(0,1,0,1,1,0,0)};  // burst_len 1
        vecs[10] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,0,0,1,0,0)};  // ARM -> RUN
        vecs[11] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,0,0,1,0,0)};  // RUN steps 1..5
        vecs[12] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,0,0,1,0,0)};
        vecs[13] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,0,0,1,0,0)};
        vecs[14] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,0,0,1,0,0)};
        vecs[15] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,0,0,1,0,0)};
        vecs[16] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,1,0,1,1,0)};  // 6th RUN step wraps, auto-stop
        vecs[17] = '{2'b01, 2'b00, 24'd1, 8'd1, ev(1,0,1,0,0,1,1)};  // done, cycle_cnt held
        vecs[18] = '{2'b01, 2'b00, 24'd1, 8'd0, ev(0,1,0,1,1,0,0)};  // held start re-granted
        vecs[19] = '{2'b00, 2'b10, 24'd1, 8'd0, ev(1,0,1,2,1,0,0)};
        vecs[20] = '{2'b00, 2'b00, 24'd1, 8'd0, ev(1,0,1,0,0,0,1)};
        vecs[21] = '{2'b00, 2'b00, 24'd1, 8'd0, ev(0,0,1,0,0,0,0)};

        // reset state
        repeat (2) cyc();
        chk("reset_outputs", {17'd0, outs()}, {17'd0, ev(0,0,1,0,0,0,0)});
        @(negedge clock);
        reset = 1'b1;
        cyc();
        chk("idle_after_reset", {17'd0, outs()}, {17'd0, ev(0,0,1,0,0,0,0)});

        // table-driven vectors
        for (int i = 0; i < NV; i++) begin
            req_start = vecs[i].rs;
            req_stop  = vecs[i].rp;
            div_val   = vecs[i].dv;
            burst_len = vecs[i].bl;
            cyc();
            $display("vec %0d rs=%b rp=%b out=%b exp=%b", i, vecs[i].rs, vecs[i].rp, outs(), vecs[i].exp);
            chk($sformatf("vec%0d", i), {17'd0, outs()}, {17'd0, vecs[i].exp});
        end

        // T2: div 4, burst 2
        div_val = 24'd4; burst_len = 8'd2; req_start = 2'b01;
        cyc();
        req_start = 2'b00;
        chk("t2_grant", {30'd0, grant}, 32'd1);
        chk("t2_start_at_grant", {31'd0, start}, 32'd1);
        nsteps = 0; last = 0; seen_done = 1'b0;
        for (int c = 1; c <= 200 && !seen_done; c++) begin
            cyc();
            if (step) begin
                nsteps++;
                chk("t2_step_gap", c - last, 32'd4);
                last = c;
                if (nsteps == 1)  chk("t2_start_drop", {31'd0, start}, 32'd0);
                if (nsteps == 6)  chk("t2_cnt_step6", {24'd0, cycle_cnt}, 32'd0);
                if (nsteps == 7)  chk("t2_cnt_step7", {24'd0, cycle_cnt}, 32'd1);
                if (nsteps == 12) chk("t2_cnt_step12", {24'd0, cycle_cnt}, 32'd1);
                if (nsteps == 13) begin
                    chk("t2_cnt_step13", {24'd0, cycle_cnt}, 32'd2);
                    chk("t2_stop_step13", {31'd0, stop}, 32'd1);
                end
                if (nsteps == 14) begin
                    chk("t2_done_step14", {31'd0, done}, 32'd1);
                    chk("t2_busy_step14", {31'd0, busy}, 32'd0);
                end
            end else begin
                if (nsteps == 0) chk("t2_start_before_step", {31'd0, start}, 32'd1);
                chk("t2_no_done_between", {31'd0, done}, 32'd0);
            end
            if (done) seen_done = 1'b1;
        end
        chk("t2_total_steps", nsteps, 32'd14);
        $display("t2 burst run: %0d steps", nsteps);

        // T3: step every clock, cycle_cnt saturation
        div_val = 24'd0; burst_len = 8'd0; req_start = 2'b01;
        cyc();
        req_start = 2'b00;
        chk("t3_grant", {30'd0, grant}, 32'd1);
        repeat (1530) cyc();
        chk("t3_cnt_254", {24'd0, cycle_cnt}, 32'd254);
        cyc();
        chk("t3_cnt_255", {24'd0, cycle_cnt}, 32'd255);
        repeat (30) cyc();
        chk("t3_cnt_saturated", {24'd0, cycle_cnt}, 32'd255);
        chk("t3_step_every_clock", {31'd0, step}, 32'd1);
        req_stop = 2'b10;
        cyc();
        req_stop = 2'b00;
        chk("t3_stop_grant", {30'd0, grant}, 32'd2);
        wait_done("t3_done", 5);
        $display("t3 saturation run: cycle_cnt=%0d", cycle_cnt);

        // T4: simultaneous stops with pointer at source 0, then start contest
        div_val = 24'd3; burst_len = 8'd0; req_start = 2'b01;
        cyc();
        req_start = 2'b00;
        chk("t4_start_grant", {30'd0, grant}, 32'd1);
        wait_step("t4_first_step", 10);
        req_stop = 2'b11;
        cyc();
        req_stop = 2'b00;
        chk("t4_stop_grant", {30'd0, grant}, 32'd2);
        chk("t4_drain_outputs", {30'd0, start, stop}, 32'd1);
        wait_done("t4_done", 10);
        req_start = 2'b11;
        cyc();
        req_start = 2'b00;
        chk("t4_start_contest", {30'd0, grant}, 32'd1);
        req_stop = 2'b01;
        cyc();
        req_stop = 2'b00;
        chk("t4_cleanup_stop", {30'd0, grant}, 32'd1);
        wait_done("t4_cleanup_done", 10);
        $display("t4 arbitration contest complete");

        // T6: stop granted in ARM, 3 clocks after start grant, div 10
        div_val = 24'd10; burst_len = 8'd0; req_start = 2'b01;
        cyc();
        req_start = 2'b00;
        chk("t6_start_grant", {30'd0, grant}, 32'd1);
        cyc();
        cyc();
        req_stop = 2'b01;
        cyc();
        req_stop = 2'b00;
        chk("t6_stop_grant", {30'd0, grant}, 32'd1);
        chk("t6_drain_outputs", {29'd0, start, stop, busy}, 32'd3);
        for (int c = 4; c <= 9; c++) begin
            cyc();
            chk($sformatf("t6_quiet_%0d", c), {30'd0, step, done}, 32'd0);
        end
        cyc();
        chk("t6_done", {17'd0, outs()}, {17'd0, ev(1,0,1,0,0,0,1)});
        $display("t6 stop during ARM complete");

        // T1: asynchronous reset mid-RUN
        div_val = 24'd1; burst_len = 8'd0; req_start = 2'b10;
        cyc();
        req_start = 2'b00;
        chk("t1_start_grant", {30'd0, grant}, 32'd2);
        repeat (12) cyc();
        chk("t1_cnt_before_reset", {24'd0, cycle_cnt}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("t1_async_reset", {17'd0, outs()}, {17'd0, ev(0,0,1,0,0,0,0)});
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("t1_idle_no_done", {17'd0, outs()}, {17'd0, ev(0,0,1,0,0,0,0)});
        end
        $display("t1 reset abort complete");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
